// File: rtl/rv32v_lane_reg_file.sv
// rv32v_lane_reg_file: vector register file for the rv32v execute stage.
// NUM_LANES elements are read or written per access. Reads are registered and
// write-first. Writes honour vl (tail) and optionally the v0 mask. A small
// engine performs whole-register move and clear, one slice per cycle.
module rv32v_lane_reg_file #(
    parameter int NUM_REGS  = 32,
    parameter int VLEN      = 128,
    parameter int NUM_LANES = 2,
    parameter int OFFW      = $clog2(VLEN) + 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [1:0]                  sew,
    input  logic [1:0]                  vs2_sew,
    input  logic [1:0]                  eew,
    input  logic [OFFW-1:0]             vl,
    input  logic                        rd_en,
    input  logic [4:0]                  vs1,
    input  logic [4:0]                  vs2,
    input  logic [4:0]                  vs3,
    input  logic [OFFW-1:0]             vs1_offset,
    input  logic [OFFW-1:0]             vs2_offset,
    input  logic [OFFW-1:0]             vs3_offset,
    output logic [NUM_LANES-1:0][31:0]  vs1_data,
    output logic [NUM_LANES-1:0][31:0]  vs2_data,
    output logic [NUM_LANES-1:0][31:0]  vs3_data,
    input  logic [OFFW-1:0]             mask_offset,
    output logic [NUM_LANES-1:0]        mask_bits,
    input  logic                        wen,
    input  logic [4:0]                  vd,
    input  logic [OFFW-1:0]             vd_offset,
    input  logic [NUM_LANES-1:0][31:0]  w_data,
    input  logic                        w_masked,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [4:0]                  cmd_src,
    input  logic [4:0]                  cmd_dst,
    input  logic [3:0]                  cmd_nregs,
    output logic                        busy,
    output logic                        done,
    output logic                        cmd_err
);

    localparam int SLICEW   = 32 * NUM_LANES;
    localparam int SLICES   = VLEN / SLICEW;
    localparam int MAXBEATS = 8 * SLICES;
    localparam int BEATW    = $clog2(MAXBEATS + 1);
    localparam int EW       = OFFW + 4;
    localparam int BOFFW    = $clog2(VLEN);
    localparam int PW       = BOFFW + BEATW;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} engState_t;

    function automatic logic [31:0] widthMask(input logic [1:0] code);
        logic [31:0] m;
        case (code)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Register holding element e of a group: base + e / (elements per register), wrapping mod 32.
    function automatic logic [4:0] elemReg(input logic [4:0] base, input logic [EW-1:0] e,
                                           input logic [1:0] code);
        logic [4:0] q;
        case (code)
            2'b00:   q = 5'(e / EW'(VLEN / 8));
            2'b01:   q = 5'(e / EW'(VLEN / 16));
            default: q = 5'(e / EW'(VLEN / 32));
        endcase
        return base + q;
    endfunction

    function automatic logic [BOFFW-1:0] bitOff(input logic [EW-1:0] e, input logic [1:0] code);
        logic [BOFFW-1:0] o;
        case (code)
            2'b00:   o = BOFFW'((e % EW'(VLEN / 8)) * EW'(8));
            2'b01:   o = BOFFW'((e % EW'(VLEN / 16)) * EW'(16));
            default: o = BOFFW'((e % EW'(VLEN / 32)) * EW'(32));
        endcase
        return o;
    endfunction

    function automatic logic [31:0] extract(input logic [VLEN-1:0] regv, input logic [BOFFW-1:0] off,
                                            input logic [1:0] code);
        return 32'(regv >> off) & widthMask(code);
    endfunction

    logic [VLEN-1:0]            r_vregs [NUM_REGS];
    logic [VLEN-1:0]            w_next  [NUM_REGS];

    logic [NUM_LANES-1:0]       w_wrEn;
    logic [EW-1:0]              w_wrElem [NUM_LANES];
    logic [4:0]                 w_wrReg  [NUM_LANES];
    logic [VLEN-1:0]            w_wrMask [NUM_LANES];
    logic [VLEN-1:0]            w_wrData [NUM_LANES];

    logic [EW-1:0]              w_e1 [NUM_LANES];
    logic [EW-1:0]              w_e2 [NUM_LANES];
    logic [EW-1:0]              w_e3 [NUM_LANES];
    logic [EW-1:0]              w_em [NUM_LANES];
    logic [NUM_LANES-1:0][31:0] w_rd1, w_rd2, w_rd3;
    logic [NUM_LANES-1:0]       w_mask;

    logic [NUM_LANES-1:0][31:0] r_vs1Data, r_vs2Data, r_vs3Data;
    logic [NUM_LANES-1:0]       r_maskBits;

    engState_t                  r_state;
    logic                       r_cmdReady, r_busy, r_done, r_cmdErr;
    logic                       r_op;
    logic [4:0]                 r_src, r_dst;
    logic [BEATW-1:0]           r_beat, r_numBeats;

    logic                       w_engWrite;
    logic [4:0]                 w_engDst, w_engSrc;
    logic [BOFFW-1:0]           w_engOff;
    logic [SLICEW-1:0]          w_engData;
    logic                       w_nregsOk, w_dstAligned, w_srcAligned, w_cmdOk;
    logic [3:0]                 w_alignMask;

    assign vs1_data  = r_vs1Data;
    assign vs2_data  = r_vs2Data;
    assign vs3_data  = r_vs3Data;
    assign mask_bits = r_maskBits;
    assign cmd_ready = r_cmdReady;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cmd_err   = r_cmdErr;

    // Per-lane datapath write decode: target register, bit lane, and tail/mask enable.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_wrElem[i] = EW'(vd_offset) + EW'(i);
            w_wrReg[i]  = elemReg(vd, w_wrElem[i], eew);
            w_wrMask[i] = VLEN'(widthMask(eew)) << bitOff(w_wrElem[i], eew);
            w_wrData[i] = VLEN'(w_data[i] & widthMask(eew)) << bitOff(w_wrElem[i], eew);
            w_wrEn[i]   = wen && (w_wrElem[i] < EW'(vl)) &&
                          (!w_masked || ((w_wrElem[i] < EW'(VLEN)) && r_vregs[0][BOFFW'(w_wrElem[i])]));
        end
    end

    // Engine beat decode and command legality; a beat only writes when the datapath is idle.
    always_comb begin
        w_engWrite   = (r_state == ST_RUN) && !wen;
        w_engDst     = r_dst + 5'(r_beat / BEATW'(SLICES));
        w_engSrc     = r_src + 5'(r_beat / BEATW'(SLICES));
        w_engOff     = BOFFW'((PW'(r_beat) % PW'(SLICES)) * PW'(SLICEW));
        w_engData    = r_op ? '0 : r_vregs[w_engSrc][w_engOff +: SLICEW];
        w_nregsOk    = (cmd_nregs == 4'd1) || (cmd_nregs == 4'd2) ||
                       (cmd_nregs == 4'd4) || (cmd_nregs == 4'd8);
        w_alignMask  = cmd_nregs - 4'd1;
        w_dstAligned = (cmd_dst[3:0] & w_alignMask) == 4'd0;
        w_srcAligned = (cmd_src[3:0] & w_alignMask) == 4'd0;
        w_cmdOk      = w_nregsOk && w_dstAligned && (cmd_op || w_srcAligned);
    end

    // Next register contents; reads look at this so they see same-cycle writes.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_next[r] = r_vregs[r];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wrEn[i] && (w_wrReg[i] == 5'(r))) begin
                    w_next[r] = (w_next[r] & ~w_wrMask[i]) | (w_wrData[i] & w_wrMask[i]);
                end
            end
        end
        if (w_engWrite) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_engDst == 5'(r)) begin
                    w_next[r][w_engOff +: SLICEW] = w_engData;
                end
            end
        end
    end

    // Read-port element selection with tail lanes forced to zero, plus v0 mask bits.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_e1[i]  = EW'(vs1_offset) + EW'(i);
            w_e2[i]  = EW'(vs2_offset) + EW'(i);
            w_e3[i]  = EW'(vs3_offset) + EW'(i);
            w_em[i]  = EW'(mask_offset) + EW'(i);
            w_rd1[i] = (w_e1[i] < EW'(vl)) ?
                       extract(w_next[elemReg(vs1, w_e1[i], sew)], bitOff(w_e1[i], sew), sew) : 32'd0;
            w_rd2[i] = (w_e2[i] < EW'(vl)) ?
                       extract(w_next[elemReg(vs2, w_e2[i], vs2_sew)], bitOff(w_e2[i], vs2_sew), vs2_sew) : 32'd0;
            w_rd3[i] = (w_e3[i] < EW'(vl)) ?
                       extract(w_next[elemReg(vs3, w_e3[i], sew)], bitOff(w_e3[i], sew), sew) : 32'd0;
            w_mask[i] = (w_em[i] < EW'(VLEN)) ? w_next[0][BOFFW'(w_em[i])] : 1'b0;
        end
    end

    // Register storage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_vregs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_vregs[r] <= w_next[r];
            end
        end
    end

    // Registered read ports (held when rd_en is low) and mask bits (every cycle).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vs1Data  <= '0;
            r_vs2Data  <= '0;
            r_vs3Data  <= '0;
            r_maskBits <= '0;
        end else begin
            if (rd_en) begin
                r_vs1Data <= w_rd1;
                r_vs2Data <= w_rd2;
                r_vs3Data <= w_rd3;
            end
            r_maskBits <= w_mask;
        end
    end

    // Move/clear engine: accept, run beats (stalling under wen), pulse done or cmd_err.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cmdReady <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cmdErr   <= 1'b0;
            r_op       <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_beat     <= '0;
            r_numBeats <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_src      <= cmd_src;
                        r_dst      <= cmd_dst;
                        r_beat     <= '0;
                        r_numBeats <= BEATW'(cmd_nregs) * BEATW'(SLICES);
                        r_cmdReady <= 1'b0;
                        if (w_cmdOk) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state  <= ST_ERR;
                            r_cmdErr <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!wen) begin
                        r_beat <= r_beat + BEATW'(1);
                        if (r_beat == r_numBeats - BEATW'(1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cmdReady <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cmdErr   <= 1'b0;
                    r_cmdReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32v_lane_reg_file.sv
// Testbench for rv32v_lane_reg_file: table of directed write/read vectors with
// hand-computed expectations, followed by sequences for write-first reads,
// mixed element widths, the move/clear engine, misaligned commands and reset.
module tb_rv32v_lane_reg_file;

    localparam int NL   = 2;
    localparam int OFFW = 8;

    logic                 CLK, RST;
    logic [1:0]           sew, vs2_sew, eew;
    logic [OFFW-1:0]      vl;
    logic                 rd_en;
    logic [4:0]           vs1, vs2, vs3;
    logic [OFFW-1:0]      vs1_offset, vs2_offset, vs3_offset;
    logic [NL-1:0][31:0]  vs1_data, vs2_data, vs3_data;
    logic [OFFW-1:0]      mask_offset;
    logic [NL-1:0]        mask_bits;
    logic                 wen;
    logic [4:0]           vd;
    logic [OFFW-1:0]      vd_offset;
    logic [NL-1:0][31:0]  w_data;
    logic                 w_masked;
    logic                 cmd_valid, cmd_ready, cmd_op;
    logic [4:0]           cmd_src, cmd_dst;
    logic [3:0]           cmd_nregs;
    logic                 busy, done, cmd_err;

    int nCompared   = 0;
    int nMismatched = 0;

    rv32v_lane_reg_file #(.NUM_REGS(32), .VLEN(128), .NUM_LANES(NL), .OFFW(OFFW)) dut (
        .CLK(CLK), .RST(RST), .sew(sew), .vs2_sew(vs2_sew), .eew(eew), .vl(vl),
        .rd_en(rd_en), .vs1(vs1), .vs2(vs2), .vs3(vs3),
        .vs1_offset(vs1_offset), .vs2_offset(vs2_offset), .vs3_offset(vs3_offset),
        .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
        .mask_offset(mask_offset), .mask_bits(mask_bits),
        .wen(wen), .vd(vd), .vd_offset(vd_offset), .w_data(w_data), .w_masked(w_masked),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_nregs(cmd_nregs),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          isWrite;
        logic [1:0]  sew;
        logic [7:0]  vl;
        logic [4:0]  vreg;
        logic [7:0]  off;
        logic        masked;
        logic [31:0] lane0;
        logic [31:0] lane1;
        logic [1:0]  expMask;
    } vec_t;

    function automatic vec_t W(logic [1:0] s, logic [7:0] l, logic [4:0] r, logic [7:0] o,
                               logic m, logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        v = '{1'b1, s, l, r, o, m, d0, d1, 2'b00};
        return v;
    endfunction

    function automatic vec_t R(logic [1:0] s, logic [7:0] l, logic [4:0] r, logic [7:0] o,
                               logic [31:0] e0, logic [31:0] e1, logic [1:0] em);
        vec_t v;
        v = '{1'b0, s, l, r, o, 1'b0, e0, e1, em};
        return v;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        sew     = v.sew;
        vs2_sew = v.sew;
        eew     = v.sew;
        vl      = v.vl;
        if (v.isWrite) begin
            wen       = 1'b1;
            vd        = v.vreg;
            vd_offset = v.off;
            w_masked  = v.masked;
            w_data[0] = v.lane0;
            w_data[1] = v.lane1;
        end else begin
            rd_en       = 1'b1;
            vs1         = v.vreg;
            vs2         = v.vreg;
            vs3         = v.vreg;
            vs1_offset  = v.off;
            vs2_offset  = v.off;
            vs3_offset  = v.off;
            mask_offset = v.off;
        end
        tick;
        wen   = 1'b0;
        rd_en = 1'b0;
        if (!v.isWrite) begin
            checkOutput({tag, " vs1 lane0"}, 64'(vs1_data[0]), 64'(v.lane0));
            checkOutput({tag, " vs1 lane1"}, 64'(vs1_data[1]), 64'(v.lane1));
            checkOutput({tag, " vs2 lane0"}, 64'(vs2_data[0]), 64'(v.lane0));
            checkOutput({tag, " vs2 lane1"}, 64'(vs2_data[1]), 64'(v.lane1));
            checkOutput({tag, " vs3 lane0"}, 64'(vs3_data[0]), 64'(v.lane0));
            checkOutput({tag, " vs3 lane1"}, 64'(vs3_data[1]), 64'(v.lane1));
            checkOutput({tag, " mask_bits"}, 64'(mask_bits), 64'(v.expMask));
        end
    endtask

    task automatic issueCmd(input logic op, input logic [4:0] src, input logic [4:0] dst,
                            input logic [3:0] nregs, input string tag);
        checkOutput({tag, " cmd_ready before accept"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_nregs = nregs;
        tick;
        cmd_valid = 1'b0;
    endtask

    // Waits for done, bounded; returns cycles counted since the accept edge in cyc.
    task automatic waitDone(inout int cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick;
            cyc++;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
    endtask

    vec_t tbl [22];
    int   cyc;
    int   donePulses;

    initial begin
        RST = 1'b1; sew = 2'd2; vs2_sew = 2'd2; eew = 2'd2; vl = '0; rd_en = 1'b0;
        vs1 = '0; vs2 = '0; vs3 = '0; vs1_offset = '0; vs2_offset = '0; vs3_offset = '0;
        mask_offset = '0; wen = 1'b0; vd = '0; vd_offset = '0; w_data = '0; w_masked = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_nregs = 4'd1;

        tbl[0]  = R(2, 4, 4, 0, 32'h0, 32'h0, 2'b00);
        tbl[1]  = W(2, 4, 4, 0, 0, 32'h11111111, 32'h22222222);
        tbl[2]  = W(2, 4, 4, 2, 0, 32'h33333333, 32'h44444444);
        tbl[3]  = R(2, 4, 4, 0, 32'h11111111, 32'h22222222, 2'b00);
        tbl[4]  = R(2, 4, 4, 2, 32'h33333333, 32'h44444444, 2'b00);
        tbl[5]  = W(0, 3, 4, 2, 0, 32'h123456AA, 32'h0000CCBB);
        tbl[6]  = R(0, 3, 4, 2, 32'hAA, 32'h0, 2'b00);
        tbl[7]  = R(0, 8, 4, 2, 32'hAA, 32'h11, 2'b00);
        tbl[8]  = R(2, 4, 4, 0, 32'h11AA1111, 32'h22222222, 2'b00);
        tbl[9]  = W(2, 4, 0, 0, 0, 32'h5, 32'h0);
        tbl[10] = R(2, 4, 0, 0, 32'h5, 32'h0, 2'b01);
        tbl[11] = W(1, 4, 6, 0, 1, 32'hFFFF, 32'hFFFF);
        tbl[12] = R(1, 4, 6, 0, 32'hFFFF, 32'h0, 2'b01);
        tbl[13] = W(1, 4, 6, 2, 1, 32'h1234, 32'h5678);
        tbl[14] = R(1, 4, 6, 2, 32'h1234, 32'h0, 2'b01);
        tbl[15] = R(1, 4, 0, 1, 32'h0, 32'h0, 2'b10);
        tbl[16] = W(1, 16, 8, 8, 0, 32'h8888, 32'h9999);
        tbl[17] = R(1, 16, 9, 0, 32'h8888, 32'h9999, 2'b01);
        tbl[18] = R(1, 16, 8, 6, 32'h0, 32'h0, 2'b00);
        tbl[19] = R(1, 16, 8, 7, 32'h0, 32'h8888, 2'b00);
        tbl[20] = W(2, 8, 8, 0, 0, 32'hA0A0A0A0, 32'hB1B1B1B1);
        tbl[21] = R(2, 8, 8, 4, 32'h99998888, 32'h0, 2'b00);

        // Reset state, checked while reset is still asserted.
        #1;
        checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset cmd_err", 64'(cmd_err), 64'd0);
        checkOutput("reset vs1_data", 64'(vs1_data), 64'd0);
        checkOutput("reset mask_bits", 64'(mask_bits), 64'd0);
        tick;
        tick;
        RST = 1'b0;
        tick;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Write-first: read and write the same elements in one cycle.
        wen = 1'b1; vd = 5'd12; vd_offset = 8'd0; eew = 2'd2; vl = 8'd4; w_masked = 1'b0;
        w_data[0] = 32'hCAFEF00D; w_data[1] = 32'h12345678;
        rd_en = 1'b1; vs1 = 5'd12; vs1_offset = 8'd0; sew = 2'd2;
        tick;
        wen = 1'b0; rd_en = 1'b0;
        checkOutput("write-first lane0", 64'(vs1_data[0]), 64'h0CAFEF00D);
        checkOutput("write-first lane1", 64'(vs1_data[1]), 64'h012345678);

        // Independent widths and offsets per port.
        rd_en = 1'b1; vl = 8'd4; sew = 2'd2; vs2_sew = 2'd0;
        vs1 = 5'd4; vs1_offset = 8'd0; vs2 = 5'd4; vs2_offset = 8'd1; vs3 = 5'd4; vs3_offset = 8'd3;
        tick;
        rd_en = 1'b0;
        checkOutput("mixed vs1 lane0", 64'(vs1_data[0]), 64'h11AA1111);
        checkOutput("mixed vs1 lane1", 64'(vs1_data[1]), 64'h22222222);
        checkOutput("mixed vs2 lane0", 64'(vs2_data[0]), 64'h11);
        checkOutput("mixed vs2 lane1", 64'(vs2_data[1]), 64'hAA);
        checkOutput("mixed vs3 lane0", 64'(vs3_data[0]), 64'h44444444);
        checkOutput("mixed vs3 lane1", 64'(vs3_data[1]), 64'h0);
        tick;
        checkOutput("held vs1 lane0 without rd_en", 64'(vs1_data[0]), 64'h11AA1111);

        // Move v8..v9 -> v16..v17 with one datapath write stalling the second beat.
        issueCmd(1'b0, 5'd8, 5'd16, 4'd2, "move");
        cyc = 0;
        checkOutput("move busy cycle1", 64'(busy), 64'd1);
        checkOutput("move cmd_ready cycle1", 64'(cmd_ready), 64'd0);
        tick;
        cyc++;
        checkOutput("move done early", 64'(done), 64'd0);
        wen = 1'b1; vd = 5'd30; vd_offset = 8'd0; eew = 2'd2; vl = 8'd4; w_masked = 1'b0;
        w_data[0] = 32'h30303030; w_data[1] = 32'h0;
        tick;
        cyc++;
        wen = 1'b0;
        checkOutput("move done during stall", 64'(done), 64'd0);
        waitDone(cyc, "move");
        checkOutput("move done latency", 64'(cyc), 64'd5);
        checkOutput("move busy at done", 64'(busy), 64'd1);
        tick;
        checkOutput("move done one pulse", 64'(done), 64'd0);
        checkOutput("move busy after", 64'(busy), 64'd0);
        checkOutput("move cmd_ready after", 64'(cmd_ready), 64'd1);
        applyStimulus(R(2, 8, 16, 0, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b01), "move v16 e0");
        applyStimulus(R(2, 8, 16, 2, 32'h0, 32'h0, 2'b01), "move v16 e2");
        applyStimulus(R(2, 8, 16, 4, 32'h99998888, 32'h0, 2'b00), "move v17 e0");
        applyStimulus(R(2, 4, 30, 0, 32'h30303030, 32'h0, 2'b01), "stall write v30");

        // Clear v16 only; v17 keeps the moved data.
        issueCmd(1'b1, 5'd0, 5'd16, 4'd1, "clear");
        cyc = 0;
        waitDone(cyc, "clear");
        checkOutput("clear done latency", 64'(cyc), 64'd2);
        tick;
        applyStimulus(R(2, 8, 16, 0, 32'h0, 32'h0, 2'b01), "clear v16 e0");
        applyStimulus(R(2, 8, 16, 4, 32'h99998888, 32'h0, 2'b00), "clear v17 kept");

        // Misaligned source: error pulse, no done, no writes.
        issueCmd(1'b0, 5'd3, 5'd20, 4'd2, "err");
        checkOutput("err cmd_err pulse", 64'(cmd_err), 64'd1);
        checkOutput("err busy", 64'(busy), 64'd0);
        donePulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (done) donePulses++;
            if (k == 0) checkOutput("err cmd_err one pulse", 64'(cmd_err), 64'd0);
        end
        checkOutput("err no done", 64'(donePulses), 64'd0);
        checkOutput("err cmd_ready back", 64'(cmd_ready), 64'd1);
        applyStimulus(R(2, 8, 20, 0, 32'h0, 32'h0, 2'b01), "err v20 untouched");
        applyStimulus(R(2, 8, 20, 4, 32'h0, 32'h0, 2'b00), "err v21 untouched");
        applyStimulus(R(2, 4, 4, 0, 32'h11AA1111, 32'h22222222, 2'b01), "err v4 untouched");

        // Illegal group size.
        issueCmd(1'b1, 5'd0, 5'd0, 4'd3, "nregs3");
        checkOutput("nregs3 cmd_err", 64'(cmd_err), 64'd1);
        tick;
        tick;
        applyStimulus(R(2, 4, 0, 0, 32'h5, 32'h0, 2'b01), "nregs3 v0 untouched");

        // Reset in the middle of an 8-register move aborts it and zeroes the file.
        issueCmd(1'b0, 5'd8, 5'd16, 4'd8, "abort");
        tick;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort cmd_ready", 64'(cmd_ready), 64'd1);
        tick;
        RST = 1'b0;
        tick;
        applyStimulus(R(2, 8, 8, 0, 32'h0, 32'h0, 2'b00), "abort v8 zeroed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
